// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - note frequency to square-wave speaker drive with serial divider and volume PWM
// New pitches are applied only at a wave boundary so the output never glitches.
module tone_synth #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int FREQ_MIN = 20,
   parameter int FREQ_MAX = 20_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] freq,
   input  logic [2:0]  vol,
   output logic        audio,
   output logic        tone_sq,
   output logic        busy,
   output logic [31:0] half_per
);

   if (CLK_HZ / (2 * FREQ_MAX) < 1) begin : g_bad_params
      $error("tone_synth: CLK_HZ too low for FREQ_MAX");
   end

   localparam logic [31:0] F_MIN    = 32'(FREQ_MIN);
   localparam logic [31:0] F_MAX    = 32'(FREQ_MAX);
   localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);

   typedef enum logic [1:0] {IDLE, DIV, PEND, RUN} state_t;

   state_t      state;
   logic [31:0] f_eff;
   logic [31:0] cur_freq;
   logic [31:0] cnt;
   logic [31:0] next_hp;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [4:0]  dcnt;
   logic [7:0]  pwm_cnt;
   logic [32:0] divisor;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        take;
   logic        at_edge;
   logic        pwm_on;

   always_comb begin
      f_eff = freq;
      if (freq < F_MIN)
         f_eff = '0;
      else if (freq > F_MAX)
         f_eff = F_MAX;
      divisor = {cur_freq, 1'b0};
      shifted = {rem, quo[31]};
      diff    = shifted - divisor;
      take    = ~diff[32];
      at_edge = (half_per != '0) && (cnt == half_per - 32'd1);
      pwm_on  = ({1'b0, pwm_cnt} < {1'b0, vol, 5'b0});
   end

   assign busy = (state == DIV);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_freq <= '0;
         cnt      <= '0;
         next_hp  <= '0;
         quo      <= '0;
         rem      <= '0;
         dcnt     <= '0;
         pwm_cnt  <= '0;
         half_per <= '0;
         tone_sq  <= 1'b0;
         audio    <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         // audio is the gated wave, one register stage behind tone_sq
         audio   <= tone_sq & pwm_on;

         if (half_per != '0) begin
            if (at_edge) begin
               cnt     <= '0;
               tone_sq <= ~tone_sq;
            end else begin
               cnt <= cnt + 32'd1;
            end
         end

         case (state)
            IDLE, RUN: begin
               if (f_eff != cur_freq) begin
                  cur_freq <= f_eff;
                  if (f_eff == '0) begin
                     next_hp <= '0;
                     state   <= PEND;
                  end else begin
                     rem   <= '0;
                     quo   <= DIVIDEND;
                     dcnt  <= '0;
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               rem  <= take ? diff[31:0] : shifted[31:0];
               quo  <= {quo[30:0], take};
               dcnt <= dcnt + 5'd1;
               if (dcnt == 5'd31) begin
                  next_hp <= {quo[30:0], take};
                  state   <= PEND;
               end
            end
            PEND: begin
               if (half_per == '0) begin
                  half_per <= next_hp;
                  if (next_hp != '0) begin
                     cnt     <= '0;
                     tone_sq <= 1'b1;
                     state   <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end else if (at_edge) begin
                  // silence only lands on a falling boundary so the last high half is complete
                  if (next_hp != '0) begin
                     half_per <= next_hp;
                     state    <= RUN;
                  end else if (tone_sq) begin
                     half_per <= '0;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - self-checking bench for tone_synth against a cycle-level behavioural model
module tb_tone_synth;

   localparam int CLK_HZ = 1_000_000;
   localparam int FMIN   = 20;
   localparam int FMAX   = 20_000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] freq = '0;
   logic [2:0]  vol = '0;
   logic        audio;
   logic        tone_sq;
   logic        busy;
   logic [31:0] half_per;

   tone_synth #(.CLK_HZ(CLK_HZ), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .freq(freq),
      .vol(vol),
      .audio(audio),
      .tone_sq(tone_sq),
      .busy(busy),
      .half_per(half_per)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int feff(input logic [31:0] f);
      if (f < FMIN) return 0;
      if (f > FMAX) return FMAX;
      return int'(f);
   endfunction

   // model: pitch request tracked as a countdown plus an arithmetic quotient
   int m_cur, m_next, m_hp, m_cnt, m_div_left, m_pwm, m_fe, m_hp0;
   bit m_pend, m_sq, m_audio, m_edge, m_sq0, started;

   always @(posedge clk) begin
      started = 1'b1;
      if (!rst_n) begin
         m_cur = 0; m_next = 0; m_hp = 0; m_cnt = 0; m_div_left = 0;
         m_pwm = 0; m_pend = 0; m_sq = 0; m_audio = 0;
      end else begin
         m_fe    = feff(freq);
         m_audio = m_sq && (m_pwm < int'(vol) * 32);
         m_pwm   = (m_pwm + 1) % 256;
         m_hp0   = m_hp;
         m_sq0   = m_sq;
         m_edge  = (m_hp0 != 0) && (m_cnt == m_hp0 - 1);
         if (m_hp0 != 0) begin
            if (m_edge) begin m_cnt = 0; m_sq = !m_sq; end
            else m_cnt++;
         end
         if (m_div_left > 0) begin
            m_div_left--;
            if (m_div_left == 0) begin
               m_next = CLK_HZ / (2 * m_cur);
               m_pend = 1;
            end
         end else if (m_pend) begin
            if (m_hp0 == 0) begin
               m_hp = m_next;
               m_pend = 0;
               if (m_next != 0) begin m_cnt = 0; m_sq = 1; end
            end else if (m_edge) begin
               if (m_next != 0) begin m_hp = m_next; m_pend = 0; end
               else if (m_sq0) begin m_hp = 0; m_pend = 0; end
            end
         end else if (m_fe != m_cur) begin
            m_cur = m_fe;
            if (m_fe == 0) begin m_next = 0; m_pend = 1; end
            else m_div_left = 32;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_audio", audio, m_audio);
         chk("model_tone_sq", tone_sq, m_sq);
         chk("model_busy", busy, m_div_left > 0);
         chk("model_half_per", half_per, m_hp);
      end
   end

   task automatic first_edge(input string name);
      int busy_cnt, k_rise;
      busy_cnt = 0;
      k_rise = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (tone_sq && k_rise == 0) k_rise = k;
      end
      chk({name, "_busy_cycles"}, busy_cnt, 32);
      chk({name, "_first_rise"}, k_rise, 34);
      chk({name, "_half_per"}, half_per, 500);
   endtask

   task automatic span(input int cycles, output int mn, output int mx);
      int run;
      bit prev, seen;
      mn = 1 << 30; mx = 0; run = 0; seen = 0;
      @(negedge clk);
      prev = tone_sq;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         run++;
         if (tone_sq != prev) begin
            if (seen) begin
               if (run < mn) mn = run;
               if (run > mx) mx = run;
            end
            seen = 1;
            run = 0;
            prev = tone_sq;
         end
      end
   endtask

   task automatic outputs_zero(input string name);
      chk({name, "_audio"}, audio, 0);
      chk({name, "_tone_sq"}, tone_sq, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_half_per"}, half_per, 0);
   endtask

   initial begin
      int mn, mx, cnt, ok, hold, r;

      // 1: reset, then 1000 Hz at full volume
      vol = 3'd7;
      freq = 32'd1000;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      outputs_zero("reset");
      rst_n = 1'b1;
      first_edge("t1");
      span(1200, mn, mx);
      chk("t1_half_min", mn, 500);
      chk("t1_half_max", mx, 500);

      // 2: retune to 2000 Hz while running
      freq = 32'd2000;
      span(2000, mn, mx);
      chk("t2_shortest", mn, 250);
      chk("t2_longest_le_500", mx <= 500, 1);
      chk("t2_half_per", half_per, 250);

      // 3: rest
      freq = 32'd0;
      ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (half_per == 0) ok = 1;
      end
      chk("t3_went_silent", ok, 1);
      repeat (20) @(negedge clk);
      outputs_zero("t3_idle");

      // 4: below range and clamped above range
      freq = 32'd5;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      chk("t4_low_busy_cycles", cnt, 0);
      chk("t4_low_half_per", half_per, 0);
      freq = 32'd50_000;
      repeat (40) @(negedge clk);
      chk("t4_clamped_half_per", half_per, 25);

      // 5: change during a divide from silence
      freq = 32'd0;
      repeat (100) @(negedge clk);
      chk("t5_silent", half_per, 0);
      freq = 32'd1000;
      repeat (11) @(negedge clk);
      chk("t5_mid_div_busy", busy, 1);
      freq = 32'd3000;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (half_per != 0) ok = 1;
      end
      chk("t5_first_load_seen", ok, 1);
      chk("t5_first_load", half_per, 500);
      ok = 0;
      for (int i = 0; i < 1200 && !ok; i++) begin
         @(negedge clk);
         if (half_per != 500) ok = 1;
      end
      chk("t5_second_load_seen", ok, 1);
      chk("t5_second_load", half_per, 166);

      // 6: reset mid-divide, then mid-run
      freq = 32'd2000;
      repeat (5) @(negedge clk);
      chk("t6_in_div", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      outputs_zero("t6_rst_div");
      freq = 32'd1000;
      rst_n = 1'b1;
      first_edge("t6_div");
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      outputs_zero("t6_rst_run");
      rst_n = 1'b1;
      first_edge("t6_run");

      // randomized requests, volumes and resets against the model
      for (int seg = 0; seg < 40; seg++) begin
         r = $urandom_range(0, 9);
         vol = 3'($urandom_range(0, 7));
         if (r == 0) freq = $urandom_range(0, 19);
         else if (r == 1) freq = 32'd50_000;
         else if (r == 3) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            freq = $urandom_range(400, 5000);
         end else if (r != 2) freq = $urandom_range(400, 5000);
         hold = $urandom_range(10, 1200);
         repeat (hold) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
